// File: rtl/demux1to2_32_if.sv
// demux1to2_32_if: producer-side and two consumer-side valid/ready buses of the 1-to-2 word demux
interface demux1to2_32_if;
  logic [31:0] IN_DATA;
  logic        IN_SEL;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] A_DATA;
  logic        A_VALID;
  logic        A_READY;
  logic [31:0] B_DATA;
  logic        B_VALID;
  logic        B_READY;
  modport master (
    output IN_DATA, IN_SEL, IN_VALID, A_READY, B_READY,
    input  IN_READY, A_DATA, A_VALID, B_DATA, B_VALID
  );
  modport slave (
    input  IN_DATA, IN_SEL, IN_VALID, A_READY, B_READY,
    output IN_READY, A_DATA, A_VALID, B_DATA, B_VALID
  );
endinterface

// File: rtl/demux1to2_32.sv
// demux1to2_32: registered 1-to-2 demux steering 32-bit words into two independent FWFT queues A/B
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of demux1to2_32_if (IN_* producer, A_* / B_* consumers)
//   A_CNT, B_CNT : words delivered per queue, present only with DEMUX1TO2_CNT_EN defined
module demux1to2_32 #(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic                clk,
  input  logic                rst,
  demux1to2_32_if.slave       bus
`ifdef DEMUX1TO2_CNT_EN
  ,
  output logic [31:0]         A_CNT,
  output logic [31:0]         B_CNT
`endif
);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [1:0][AW:0] w_cnt;
  logic [1:0][31:0] w_head;
  logic [1:0]       w_ready;
  logic [1:0]       w_pop;
  logic             w_accept;
  assign w_ready      = {bus.B_READY, bus.A_READY};
  // readiness looks only at the selected queue's registered count, never at the consumers
  assign bus.IN_READY = w_cnt[bus.IN_SEL] != FULL;
  assign w_accept     = bus.IN_VALID & bus.IN_READY;
  for (genvar g = 0; g < 2; g++) begin : g_q
    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;
    logic          w_push;
    assign w_push   = w_accept & (bus.IN_SEL == 1'(g));
    assign w_pop[g] = (r_cnt != '0) & w_ready[g];
    // pointers wrap naturally because DEPTH is 2**AW
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
        for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
        if (w_push) begin
          r_mem[r_wp] <= bus.IN_DATA;
          r_wp        <= r_wp + AW'(1);
        end
        if (w_pop[g]) r_rp <= r_rp + AW'(1);
        r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop[g]);
      end
    assign w_cnt[g]  = r_cnt;
    assign w_head[g] = r_mem[r_rp];
  end
  assign bus.A_VALID = w_cnt[0] != '0;
  assign bus.B_VALID = w_cnt[1] != '0;
  assign bus.A_DATA  = w_head[0];
  assign bus.B_DATA  = w_head[1];
`ifdef DEMUX1TO2_CNT_EN
  logic [31:0] r_a_cnt;
  logic [31:0] r_b_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_a_cnt <= '0;
      r_b_cnt <= '0;
    end else begin
      if (w_pop[0]) r_a_cnt <= r_a_cnt + 32'd1;
      if (w_pop[1]) r_b_cnt <= r_b_cnt + 32'd1;
    end
  assign A_CNT = r_a_cnt;
  assign B_CNT = r_b_cnt;
`endif
endmodule

// File: tb/tb_demux1to2_32.sv
// tb_demux1to2_32: table-driven, directed and randomized checks of demux1to2_32 against a queue model
module tb_demux1to2_32;
  localparam int DEPTH = 2;
  typedef struct packed {
    logic [31:0] d;
    logic        s, v, ar, br;
    logic        rdy, av, bv;
    logic [31:0] ad, bd;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  demux1to2_32_if bus ();
`ifdef DEMUX1TO2_CNT_EN
  logic [31:0] a_cnt, b_cnt;
`endif
  demux1to2_32 #(.DEPTH(DEPTH), .AW(1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef DEMUX1TO2_CNT_EN
    ,
    .A_CNT(a_cnt),
    .B_CNT(b_cnt)
`endif
  );
  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] ca, cb;
  vec_t tbl [13];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic apply(input logic [31:0] d, input logic s, input logic v, input logic ar, input logic br);
    bus.IN_DATA  = d;
    bus.IN_SEL   = s;
    bus.IN_VALID = v;
    bus.A_READY  = ar;
    bus.B_READY  = br;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    qa.delete();
    qb.delete();
    ca = '0;
    cb = '0;
  endtask
  // compare outputs with the model for the current cycle, then advance the model past the next edge
  task automatic model_cycle;
    logic exp_rdy;
    logic pa, pb;
    exp_rdy = (bus.IN_SEL ? qb.size() : qa.size()) != DEPTH;
    chk("rnd in_ready", 32'(bus.IN_READY), 32'(exp_rdy));
    chk("rnd a_valid", 32'(bus.A_VALID), 32'(qa.size() != 0));
    chk("rnd b_valid", 32'(bus.B_VALID), 32'(qb.size() != 0));
    if (qa.size() != 0) chk("rnd a_data", bus.A_DATA, qa[0]);
    if (qb.size() != 0) chk("rnd b_data", bus.B_DATA, qb[0]);
`ifdef DEMUX1TO2_CNT_EN
    chk("rnd a_cnt", a_cnt, ca);
    chk("rnd b_cnt", b_cnt, cb);
`endif
    pa = qa.size() != 0 && bus.A_READY;
    pb = qb.size() != 0 && bus.B_READY;
    if (pa) begin void'(qa.pop_front()); ca = ca + 1; end
    if (pb) begin void'(qb.pop_front()); cb = cb + 1; end
    if (bus.IN_VALID && exp_rdy) begin
      if (bus.IN_SEL) qb.push_back(bus.IN_DATA);
      else qa.push_back(bus.IN_DATA);
    end
  endtask
  function automatic vec_t mk(input logic [31:0] d, input logic s, v, ar, br, rdy, av, bv,
                              input logic [31:0] ad, bd);
    return '{d, s, v, ar, br, rdy, av, bv, ad, bd};
  endfunction
  initial begin
    apply(0, 0, 0, 0, 0);
    tbl[0]  = mk(32'h11111111, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    tbl[1]  = mk(32'hB0, 1, 1, 0, 0, 1, 1, 0, 32'h11111111, 0);
    tbl[2]  = mk(32'hB1, 1, 1, 0, 0, 1, 1, 1, 32'h11111111, 32'hB0);
    tbl[3]  = mk(32'hB2, 1, 1, 0, 0, 0, 1, 1, 32'h11111111, 32'hB0);
    tbl[4]  = mk(32'hA0, 0, 1, 0, 0, 1, 1, 1, 32'h11111111, 32'hB0);
    tbl[5]  = mk(0, 0, 0, 0, 1, 0, 1, 1, 32'h11111111, 32'hB0);
    tbl[6]  = mk(0, 0, 0, 0, 1, 0, 1, 1, 32'h11111111, 32'hB1);
    tbl[7]  = mk(0, 1, 0, 0, 1, 1, 1, 0, 32'h11111111, 0);
    tbl[8]  = mk(32'hA1, 0, 1, 1, 0, 0, 1, 0, 32'h11111111, 0);
    tbl[9]  = mk(32'hA1, 0, 1, 0, 0, 1, 1, 0, 32'hA0, 0);
    tbl[10] = mk(0, 0, 0, 1, 0, 0, 1, 0, 32'hA0, 0);
    tbl[11] = mk(0, 0, 0, 1, 0, 1, 1, 0, 32'hA1, 0);
    tbl[12] = mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    do_reset();
    @(negedge clk);
    chk("reset in_ready", 32'(bus.IN_READY), 1);
    chk("reset a_valid", 32'(bus.A_VALID), 0);
    chk("reset b_valid", 32'(bus.B_VALID), 0);
    chk("reset a_data", bus.A_DATA, 0);
    chk("reset b_data", bus.B_DATA, 0);
`ifdef DEMUX1TO2_CNT_EN
    chk("reset a_cnt", a_cnt, 0);
    chk("reset b_cnt", b_cnt, 0);
`endif
    for (int i = 0; i < 13; i++) begin
      @(posedge clk);
      #1 apply(tbl[i].d, tbl[i].s, tbl[i].v, tbl[i].ar, tbl[i].br);
      @(negedge clk);
      chk($sformatf("tbl%0d in_ready", i), 32'(bus.IN_READY), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d a_valid", i), 32'(bus.A_VALID), 32'(tbl[i].av));
      chk($sformatf("tbl%0d b_valid", i), 32'(bus.B_VALID), 32'(tbl[i].bv));
      if (tbl[i].av) chk($sformatf("tbl%0d a_data", i), bus.A_DATA, tbl[i].ad);
      if (tbl[i].bv) chk($sformatf("tbl%0d b_data", i), bus.B_DATA, tbl[i].bd);
    end
`ifdef DEMUX1TO2_CNT_EN
    chk("tbl a_cnt", a_cnt, 3);
    chk("tbl b_cnt", b_cnt, 2);
`endif
    // streaming 0..9 into A with the consumer always ready, across several pointer wraps
    do_reset();
    for (int k = 0; k <= 10; k++) begin
      @(posedge clk);
      #1 apply(32'(k), 0, k < 10, 1, 0);
      @(negedge clk);
      chk($sformatf("stream%0d in_ready", k), 32'(bus.IN_READY), 1);
      chk($sformatf("stream%0d a_valid", k), 32'(bus.A_VALID), 32'(k >= 1));
      if (k >= 1) chk($sformatf("stream%0d a_data", k), bus.A_DATA, 32'(k - 1));
    end
    @(posedge clk);
    #1 apply(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("stream drained", 32'(bus.A_VALID), 0);
`ifdef DEMUX1TO2_CNT_EN
    chk("stream a_cnt", a_cnt, 10);
`endif
    // asynchronous reset with both queues holding two words
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1 apply(32'hC0 + 32'(k), k >= 2, 1, 0, 0);
    end
    @(posedge clk);
    #1 apply(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("prerst a_valid", 32'(bus.A_VALID), 1);
    chk("prerst b_data", bus.B_DATA, 32'hC2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst a_valid", 32'(bus.A_VALID), 0);
    chk("midrst b_valid", 32'(bus.B_VALID), 0);
    chk("midrst in_ready", 32'(bus.IN_READY), 1);
    chk("midrst a_data", bus.A_DATA, 0);
    chk("midrst b_data", bus.B_DATA, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    apply(0, 1, 0, 1, 1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("postrst a_valid", 32'(bus.A_VALID), 0);
      chk("postrst b_valid", 32'(bus.B_VALID), 0);
      @(posedge clk);
    end
`ifdef DEMUX1TO2_CNT_EN
    do_reset();
    force dut.r_a_cnt = 32'hFFFFFFFF;
    #1 release dut.r_a_cnt;
    @(posedge clk);
    #1 apply(32'h5, 0, 1, 0, 0);
    @(posedge clk);
    #1 apply(0, 0, 0, 1, 0);
    @(negedge clk);
    chk("wrap pre a_cnt", a_cnt, 32'hFFFFFFFF);
    @(posedge clk);
    #1 apply(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("wrap a_cnt", a_cnt, 0);
`endif
    // randomized traffic with consumer readiness varying in phases
    do_reset();
    for (int p = 0; p < 6; p++) begin
      int unsigned pa_pct, pb_pct;
      pa_pct = $urandom_range(10, 100);
      pb_pct = $urandom_range(10, 100);
      for (int k = 0; k < 80; k++) begin
        @(posedge clk);
        #1 apply($urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                 $urandom_range(1, 100) <= pa_pct, $urandom_range(1, 100) <= pb_pct);
        @(negedge clk);
        model_cycle();
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/demux1to2_32.md
# demux1to2_32

Registered 1-to-2 demultiplexer for 32-bit words, the steering counterpart of the 2:1 datapath select muxes. It accepts one word per cycle from a single producer (e.g. the ALU/load result path) with a valid/ready handshake. Each word is routed by a per-word select bit into one of two independent output queues, A or B. Each queue drains to its own consumer under valid/ready, so one consumer stalling never corrupts or reorders the other stream.

## Interface
Parameters:
- DEPTH, 2: entries per output queue; power of two, 2..16.
- AW, 1: pointer width, log2(DEPTH); must match DEPTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- IN_DATA  in  32  word to route.
- IN_SEL  in  1  0 routes to A, 1 routes to B.
- IN_VALID  in  1  producer has a word.
- IN_READY  out  1  selected queue can accept.
- A_DATA  out  32  head of queue A.
- A_VALID  out  1  queue A non-empty.
- A_READY  in  1  consumer A takes the head.
- B_DATA  out  32  head of queue B.
- B_VALID  out  1  queue B non-empty.
- B_READY  in  1  consumer B takes the head.
- A_CNT  out  32  words delivered on A (DEMUX1TO2_CNT_EN only).
- B_CNT  out  32  words delivered on B (DEMUX1TO2_CNT_EN only).

## Operation
- Each queue is a circular buffer: DEPTH x 32 storage, write pointer, read pointer, count register of AW+1 bits.
- IN_READY = (IN_SEL ? B_count : A_count) != DEPTH. It is combinational on IN_SEL and the registered counts, and does not depend on A_READY or B_READY.
- Accept = IN_VALID & IN_READY. On the clock edge, IN_DATA is written at the selected queue's write pointer, that pointer increments modulo DEPTH, and the count increments.
- x_VALID = (x_count != 0). x_DATA = storage[x_rdptr] (first-word-fall-through).
- Pop x = x_VALID & x_READY. The read pointer increments modulo DEPTH and the count decrements.
- Push and pop on the same queue in the same cycle leave the count unchanged and advance both pointers.
- Full queue with a pop in the same cycle: IN_READY is still 0 that cycle. There is no pass-through, and the push is accepted the next cycle.
- Empty queue: no bypass. A word is never visible on x_DATA in the cycle it is accepted.
- x_READY asserted while x_VALID=0 is ignored.
- Order is preserved per queue. There is no ordering relation between A and B.
- IN_SEL and IN_DATA are sampled only on accept. The producer may change IN_SEL while stalled, and IN_READY re-evaluates immediately.

## Timing
- Reset (async assert, sync deassert by the driver): all pointers and counts 0, storage 0, IN_READY=1, A_VALID=B_VALID=0, A_DATA=B_DATA=0, A_CNT=B_CNT=0.
- Latency: a word accepted at edge N is valid on its output from edge N, so it is visible in cycle N+1.
- Throughput: one accept per cycle, plus one pop per queue per cycle.
- Reset mid-operation: all queued words are discarded immediately, and outputs take their reset values asynchronously.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble.

## Configuration
- DEMUX1TO2_CNT_EN defined: A_CNT and B_CNT exist. Each is a 32-bit register that increments on every pop of its queue and wraps from 0xFFFFFFFF to 0. Both reset to 0.
- DEMUX1TO2_CNT_EN undefined: the A_CNT and B_CNT ports and their logic are absent. All other behaviour is identical.

## Test plan
- After reset: IN_READY=1, both VALIDs 0, both DATAs 0, counters 0. Then push 0x11111111 with SEL=0: A_VALID=1 and A_DATA=0x11111111 one edge later, B_VALID stays 0.
- DEPTH=2, B_READY=0, push 0xB0, 0xB1 with SEL=1: IN_READY=0 while SEL=1. Switch SEL=0: IN_READY=1 and 0xA0 is accepted into A. Release B_READY: 0xB0 then 0xB1 drain in order.
- Queue A full, A_READY=1 and IN_VALID=1 with SEL=0 in the same cycle: pop occurs, no push. The push is accepted the next cycle and the count stays at DEPTH.
- Continuous streaming of 0..9 to A with A_READY=1: one word per cycle with no gaps across pointer wrap, A_CNT=10 (CNT_EN).
- Load 2 words into each queue, assert rst mid-cycle: A_VALID, B_VALID and IN_READY reach 0, 0, 1 asynchronously, and no stale word appears after release.
- CNT_EN with A_CNT preset near wrap (force 0xFFFFFFFF): one pop gives A_CNT=0. With the macro undefined, the build has no A_CNT or B_CNT port.
